trading_logic: RTL and testbench

- Per-stock market-making quote engine, a simplified Avellaneda-Stoikov model.
- Takes top-of-book best ask/bid, normalised session time and signed inventory for one of NUM_STOCKS instruments.
- Keeps a rolling per-stock volatility estimate and emits a buy/sell quote pair through a fixed-latency pipeline.
- Sits between the order-book/inventory tracker and the order generator.

---
 rtl/trading_logic_pkg.sv | 22 ++
 rtl/trading_logic_volatility.sv | 75 +++++++
 rtl/trading_logic.sv | 147 ++++++++++++++
 tb/tb_trading_logic.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trading_logic_pkg.sv
// Shared fixed-point constants and helpers for the market-making quote engine.
// All fixed-point words are Q32.32.
package trading_logic_pkg;

    typedef logic [63:0] fp_t;

    localparam fp_t GAMMA        = 64'h0000_0000_1999_999A;
    localparam fp_t SPREAD_CONST = 64'h0000_0001_4A71_DE6A;
    localparam fp_t ONE_FP       = 64'h0000_0001_0000_0000;

    // Unsigned Q32.32 multiply, saturating to the full word.
    function automatic fp_t fp_mul_sat(input fp_t a, input fp_t b);
        logic [127:0] p;
        p = ({64'h0, a} * {64'h0, b}) >> 32;
        return (|p[127:64]) ? '1 : p[63:0];
    endfunction

    function automatic fp_t fp_tau(input fp_t t);
        return (t > ONE_FP) ? '0 : ONE_FP - t;
    endfunction

endpackage

// File: rtl/trading_logic_volatility.sv
// Per-stock rolling sum of squared mid-price deltas over a circular window.
// Read-modify-write happens in one cycle, so back-to-back samples need no bypass.
module trading_logic_volatility
    import trading_logic_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 32,
    localparam int ID_W  = $clog2(NUM_STOCKS),
    localparam int PTR_W = $clog2(BUFFER_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [ID_W-1:0]       id,
    input  logic [DATA_WIDTH-1:0] mid,
    output fp_t                   sigma2
);

    localparam int SHIFT = 32 - PTR_W;

    logic [DATA_WIDTH-1:0] last_mid [NUM_STOCKS];
    logic                  seen     [NUM_STOCKS];
    logic [PTR_W-1:0]      ptr      [NUM_STOCKS];
    fp_t                   sum      [NUM_STOCKS];
    fp_t                   buffer   [NUM_STOCKS][BUFFER_SIZE];

    logic signed [DATA_WIDTH:0] d;
    logic signed [65:0]         d_ext;
    logic [65:0]                sq_full;
    logic [65:0]                acc;
    fp_t                        sq;
    fp_t                        old;
    fp_t                        sum_nxt;
    fp_t                        sigma_nxt;

    always_comb begin
        d = '0;
        if (seen[id])
            d = $signed({1'b0, mid}) - $signed({1'b0, last_mid[id]});
        d_ext   = 66'(d);
        sq_full = d_ext * d_ext;
        sq      = (|sq_full[65:64]) ? '1 : sq_full[63:0];
        old     = buffer[id][ptr[id]];
        // Saturate the add first, then floor the subtract at zero.
        acc = {2'b00, sum[id]} + {2'b00, sq};
        if (acc[64])
            acc = {2'b00, {64{1'b1}}};
        acc       = acc - {2'b00, old};
        sum_nxt   = acc[65] ? '0 : acc[63:0];
        sigma_nxt = ((sum_nxt >> (64 - SHIFT)) != '0) ? '1 : (sum_nxt << SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sigma2 <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                last_mid[s] <= '0;
                seen[s]     <= 1'b0;
                ptr[s]      <= '0;
                sum[s]      <= '0;
                for (int b = 0; b < BUFFER_SIZE; b++)
                    buffer[s][b] <= '0;
            end
        end else if (valid) begin
            last_mid[id]        <= mid;
            seen[id]            <= 1'b1;
            ptr[id]             <= PTR_W'(ptr[id] + 1'b1);
            sum[id]             <= sum_nxt;
            buffer[id][ptr[id]] <= sq;
            sigma2              <= sigma_nxt;
        end
    end

endmodule

// File: rtl/trading_logic.sv
// Avellaneda-Stoikov style quote engine: 4-stage pipeline from top-of-book
// and inventory to a rounded, saturated bid/ask quote pair.
module trading_logic
    import trading_logic_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FP_WORD_SIZE = 64,
    parameter int NUM_STOCKS   = 4,
    parameter int BUFFER_SIZE  = 32,
    localparam int ID_W = $clog2(NUM_STOCKS)
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [DATA_WIDTH-1:0]   i_best_ask,
    input  logic [DATA_WIDTH-1:0]   i_best_bid,
    input  logic [FP_WORD_SIZE-1:0] i_curr_time,
    input  logic [FP_WORD_SIZE-1:0] i_inventory_state,
    input  logic                    i_data_valid,
    input  logic [ID_W-1:0]         i_stock_id,
    output logic [DATA_WIDTH-1:0]   o_buy_price,
    output logic [DATA_WIDTH-1:0]   o_sell_price,
    output logic                    o_data_valid
);

    localparam int W = 100;
    localparam logic [W-1:0] ROUND = W'(64'h8000_0000);

    logic                  s1_valid, s2_valid, s3_valid;
    logic [ID_W-1:0]       s1_id;
    logic [DATA_WIDTH-1:0] s1_mid, s2_mid, s3_mid;
    fp_t                   s1_time, s1_q, s2_q, s2_tau;
    fp_t                   sigma2;
    logic signed [95:0]    s3_skew;
    fp_t                   s3_half;

    logic [DATA_WIDTH:0]   mid_sum;
    fp_t                   gst;
    logic signed [127:0]   skew_full;
    logic [64:0]           half_sum;
    logic [W-1:0]          mid_fx, skew_ext, half_ext;
    logic signed [W-1:0]   buy_fx, sell_fx;

    function automatic logic [DATA_WIDTH-1:0] sat_px(input logic signed [W-1:0] v);
        logic signed [W-33:0] i;
        i = (W-32)'(v >>> 32);
        if (i[W-33])
            return '0;
        if ((i >> DATA_WIDTH) != '0)
            return '1;
        return i[DATA_WIDTH-1:0];
    endfunction

    assign mid_sum = {1'b0, i_best_ask} + {1'b0, i_best_bid};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_mid   <= '0;
            s1_time  <= '0;
            s1_q     <= '0;
        end else begin
            s1_valid <= i_data_valid;
            if (i_data_valid) begin
                s1_id   <= i_stock_id;
                s1_mid  <= DATA_WIDTH'(mid_sum >> 1);
                s1_time <= 64'(i_curr_time);
                s1_q    <= 64'(i_inventory_state);
            end
        end
    end

    trading_logic_volatility #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_STOCKS  (NUM_STOCKS),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_vol (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .valid  (s1_valid),
        .id     (s1_id),
        .mid    (s1_mid),
        .sigma2 (sigma2)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_valid <= 1'b0;
            s2_mid   <= '0;
            s2_q     <= '0;
            s2_tau   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mid <= s1_mid;
                s2_q   <= s1_q;
                s2_tau <= fp_tau(s1_time);
            end
        end
    end

    always_comb begin
        gst       = fp_mul_sat(fp_mul_sat(GAMMA, sigma2), s2_tau);
        skew_full = $signed(s2_q) * $signed({1'b0, gst});
        half_sum  = {1'b0, gst} + {1'b0, SPREAD_CONST};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s3_valid <= 1'b0;
            s3_mid   <= '0;
            s3_skew  <= '0;
            s3_half  <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_mid  <= s2_mid;
                s3_skew <= 96'(skew_full >>> 32);
                s3_half <= 64'(half_sum >> 1);
            end
        end
    end

    // Reservation price r = mid - skew, quotes at r -/+ half, rounded half-up.
    always_comb begin
        mid_fx   = {{(W-DATA_WIDTH-32){1'b0}}, s3_mid, 32'h0};
        skew_ext = {{(W-96){s3_skew[95]}}, s3_skew};
        half_ext = {{(W-64){1'b0}}, s3_half};
        buy_fx   = $signed(mid_fx - skew_ext - half_ext + ROUND);
        sell_fx  = $signed(mid_fx - skew_ext + half_ext + ROUND);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_buy_price  <= '0;
            o_sell_price <= '0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= s3_valid;
            if (s3_valid) begin
                o_buy_price  <= sat_px(buy_fx);
                o_sell_price <= sat_px(sell_fx);
            end
        end
    end

endmodule

// File: tb/tb_trading_logic.sv
// Directed bench for trading_logic: latency, quote math, saturation,
// per-stock isolation, window roll-off and mid-flight reset.
module tb_trading_logic;

    localparam logic [63:0] Q0   = 64'h0;
    localparam logic [63:0] QP10 = 64'h0000_000A_0000_0000;
    localparam logic [63:0] QN10 = 64'hFFFF_FFF6_0000_0000;
    localparam logic [63:0] T0   = 64'h0;
    localparam logic [63:0] T2   = 64'h0000_0002_0000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic [31:0] i_best_ask = '0;
    logic [31:0] i_best_bid = '0;
    logic [63:0] i_curr_time = '0;
    logic [63:0] i_inventory_state = '0;
    logic        i_data_valid = 1'b0;
    logic [1:0]  i_stock_id = '0;
    logic [31:0] o_buy_price;
    logic [31:0] o_sell_price;
    logic        o_data_valid;

    int tests = 0;
    int fails = 0;

    trading_logic dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_best_ask        (i_best_ask),
        .i_best_bid        (i_best_bid),
        .i_curr_time       (i_curr_time),
        .i_inventory_state (i_inventory_state),
        .i_data_valid      (i_data_valid),
        .i_stock_id        (i_stock_id),
        .o_buy_price       (o_buy_price),
        .o_sell_price      (o_sell_price),
        .o_data_valid      (o_data_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic reset_dut();
        i_data_valid = 1'b0;
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    task automatic drive(input logic [1:0] id, input logic [31:0] ask, input logic [31:0] bid,
                         input logic [63:0] t, input logic [63:0] q);
        i_stock_id        = id;
        i_best_ask        = ask;
        i_best_bid        = bid;
        i_curr_time       = t;
        i_inventory_state = q;
        i_data_valid      = 1'b1;
    endtask

    task automatic run_one(input logic [1:0] id, input logic [31:0] ask, input logic [31:0] bid,
                           input logic [63:0] t, input logic [63:0] q,
                           output logic [31:0] b, output logic [31:0] s, output logic v);
        drive(id, ask, bid, t, q);
        @(posedge i_clk);
        #1 i_data_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        b = o_buy_price;
        s = o_sell_price;
        v = o_data_valid;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        tests++;
        if ({o_buy_price, o_sell_price, o_data_valid} !== 65'h0) begin
            fails++;
            $display("FAIL reset_state: got %h/%h v=%b want 0/0 v=0", o_buy_price, o_sell_price, o_data_valid);
        end
        i_reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] b, s;
        logic v;
        reset_dut();
        drive(2'd0, 32'd100, 32'd100, T0, Q0);
        @(posedge i_clk);
        #1 i_data_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        tests++;
        if (o_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_strobe: got v=%b want 0", o_data_valid);
        end
        @(posedge i_clk);
        #1;
        tests++;
        if ({o_data_valid, o_buy_price, o_sell_price} !== {1'b1, 32'd99, 32'd101}) begin
            fails++;
            $display("FAIL first_sample: got v=%b %0d/%0d want v=1 99/101", o_data_valid, o_buy_price, o_sell_price);
        end
        @(posedge i_clk);
        #1;
        tests++;
        if ({o_data_valid, o_buy_price, o_sell_price} !== {1'b0, 32'd99, 32'd101}) begin
            fails++;
            $display("FAIL strobe_hold: got v=%b %0d/%0d want v=0 99/101", o_data_valid, o_buy_price, o_sell_price);
        end
        run_one(2'd0, 32'd104, 32'd104, T0, Q0, b, s, v);
        tests++;
        if ({v, b, s} !== {1'b1, 32'd103, 32'd105}) begin
            fails++;
            $display("FAIL vol_step: got v=%b %0d/%0d want v=1 103/105", v, b, s);
        end
    endtask

    task automatic test_inventory();
        logic [31:0] b, s;
        logic v;
        reset_dut();
        run_one(2'd0, 32'd100, 32'd100, T0, Q0, b, s, v);
        run_one(2'd0, 32'd104, 32'd104, T0, QP10, b, s, v);
        tests++;
        if ({v, b, s} !== {1'b1, 32'd103, 32'd104}) begin
            fails++;
            $display("FAIL long_skew: got v=%b %0d/%0d want v=1 103/104", v, b, s);
        end
        reset_dut();
        run_one(2'd0, 32'd100, 32'd100, T0, Q0, b, s, v);
        run_one(2'd0, 32'd104, 32'd104, T0, QN10, b, s, v);
        tests++;
        if ({v, b, s} !== {1'b1, 32'd104, 32'd105}) begin
            fails++;
            $display("FAIL short_skew: got v=%b %0d/%0d want v=1 104/105", v, b, s);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] b, s;
        logic v;
        reset_dut();
        run_one(2'd0, 32'd0, 32'd0, T0, Q0, b, s, v);
        tests++;
        if ({b, s} !== {32'd0, 32'd1}) begin
            fails++;
            $display("FAIL sat_low: got %0d/%0d want 0/1", b, s);
        end
        run_one(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, T0, Q0, b, s, v);
        tests++;
        if ({b, s} !== {32'hFFFF_FFFE, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL sat_high: got %h/%h want fffffffe/ffffffff", b, s);
        end
        run_one(2'd2, 32'hFFFF_FFFF, 32'd1, T0, Q0, b, s, v);
        tests++;
        if ({b, s} !== {32'h7FFF_FFFF, 32'h8000_0001}) begin
            fails++;
            $display("FAIL mid_carry: got %h/%h want 7fffffff/80000001", b, s);
        end
        run_one(2'd3, 32'd100, 32'd100, T2, Q0, b, s, v);
        run_one(2'd3, 32'd104, 32'd104, T2, QP10, b, s, v);
        tests++;
        if ({b, s} !== {32'd103, 32'd105}) begin
            fails++;
            $display("FAIL tau_clamp: got %0d/%0d want 103/105", b, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b, s;
        logic v;
        logic [31:0] exp_b [3];
        logic [31:0] exp_s [3];
        exp_b = '{32'd99, 32'd199, 32'd103};
        exp_s = '{32'd101, 32'd201, 32'd105};
        reset_dut();
        drive(2'd1, 32'd100, 32'd100, T0, Q0);
        @(posedge i_clk);
        #1 drive(2'd2, 32'd200, 32'd200, T0, Q0);
        @(posedge i_clk);
        #1 drive(2'd1, 32'd104, 32'd104, T0, Q0);
        @(posedge i_clk);
        #1 i_data_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            tests++;
            if ({o_data_valid, o_buy_price, o_sell_price} !== {1'b1, exp_b[k], exp_s[k]}) begin
                fails++;
                $display("FAIL b2b_%0d: got v=%b %0d/%0d want v=1 %0d/%0d",
                         k, o_data_valid, o_buy_price, o_sell_price, exp_b[k], exp_s[k]);
            end
        end
        @(posedge i_clk);
        #1;
        tests++;
        if (o_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got v=%b want 0", o_data_valid);
        end
        run_one(2'd2, 32'd200, 32'd200, T0, QP10, b, s, v);
        tests++;
        if ({v, b, s} !== {1'b1, 32'd199, 32'd201}) begin
            fails++;
            $display("FAIL isolation: got v=%b %0d/%0d want v=1 199/201", v, b, s);
        end
    endtask

    task automatic test_window();
        logic [31:0] b, s;
        logic v;
        logic [31:0] want_s;
        reset_dut();
        run_one(2'd1, 32'd100, 32'd100, T0, Q0, b, s, v);
        run_one(2'd1, 32'd104, 32'd104, T0, Q0, b, s, v);
        // The delta of 4 sits in slot 1 and is evicted by sample 34.
        for (int k = 3; k <= 34; k++) begin
            run_one(2'd1, 32'd104, 32'd104, T0, QP10, b, s, v);
            want_s = (k <= 33) ? 32'd104 : 32'd105;
            tests++;
            if ({v, b, s} !== {1'b1, 32'd103, want_s}) begin
                fails++;
                $display("FAIL window_%0d: got v=%b %0d/%0d want v=1 103/%0d", k, v, b, s, want_s);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] b, s;
        logic v;
        int strobes;
        reset_dut();
        run_one(2'd0, 32'd100, 32'd100, T0, Q0, b, s, v);
        drive(2'd0, 32'd104, 32'd104, T0, Q0);
        @(posedge i_clk);
        #1 i_data_valid = 1'b0;
        @(posedge i_clk);
        #1 i_reset_n = 1'b0;
        #1;
        tests++;
        if ({o_buy_price, o_sell_price, o_data_valid} !== 65'h0) begin
            fails++;
            $display("FAIL async_clear: got %0d/%0d v=%b want 0/0 v=0", o_buy_price, o_sell_price, o_data_valid);
        end
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        strobes = 0;
        repeat (5) begin
            @(posedge i_clk);
            #1;
            if (o_data_valid === 1'b1)
                strobes++;
        end
        tests++;
        if (strobes !== 0) begin
            fails++;
            $display("FAIL stale_strobe: got %0d strobes want 0", strobes);
        end
        run_one(2'd0, 32'd104, 32'd104, T0, QP10, b, s, v);
        tests++;
        if ({v, b, s} !== {1'b1, 32'd103, 32'd105}) begin
            fails++;
            $display("FAIL post_reset_first: got v=%b %0d/%0d want v=1 103/105", v, b, s);
        end
    endtask

    initial begin
        #3 i_reset_n = 1'b0;
        test_reset();
        test_basic();
        test_inventory();
        test_saturation();
        test_back_to_back();
        test_window();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
